// File: rtl/multi_freq_gen.sv
// multi_freq_gen: N-channel fractional clock divider with programmable duty and phase,
// started together on period_stable and reprogrammed glitch-free at period boundaries.
module multi_freq_gen #(
  parameter int N = 4,
  parameter int CNT_W = 16,
  parameter int FRAC_W = 10,
  parameter int DEF_DIV = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic                             PWRDWN,
  input  logic                             period_stable,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [(N > 1 ? $clog2(N) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                 cfg_div_int,
  input  logic [FRAC_W-1:0]                cfg_div_frac,
  input  logic [CNT_W-1:0]                 cfg_high,
  input  logic [CNT_W-1:0]                 cfg_phase,
  output logic [N-1:0]                     out,
  output logic [N*CNT_W-1:0]               period_last,
  output logic [N-1:0]                     period_valid,
  output logic                             locked
);
  localparam int CH_W = N > 1 ? $clog2(N) : 1;
  localparam int PW = 2 ** CH_W;
  typedef struct packed {
    logic [CNT_W-1:0]  div;
    logic [CNT_W-1:0]  high;
    logic [CNT_W-1:0]  phase;
    logic [FRAC_W-1:0] frac;
  } cfg_t;
  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;
  localparam cfg_t DEF_CFG = '{div: CNT_W'(DEF_DIV), high: CNT_W'(DEF_HIGH), phase: '0, frac: '0};
  logic [N-1:0] pend, seen;
  logic [PW-1:0] pend_x;
  logic go;
  assign go = period_stable && !PWRDWN;
  assign pend_x = PW'(pend);
  assign cfg_ready = !pend_x[cfg_ch];
  assign locked = &seen;
  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t st;
    cfg_t act, shd, nc;
    logic [CNT_W-1:0] cnt, dcnt, p, pl, d_eff, p_n, h_n, h_eff;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0] sum;
    logic take, bnd, enter, apply, pnd, sn, o, pv;
    // nc is the config that governs the period starting on this edge
    always_comb begin
      take  = cfg_valid && cfg_ready && cfg_ch == CH_W'(i);
      bnd   = st == RUN && cnt == p - 1'b1;
      enter = st == DELAY && dcnt == '0;
      apply = pnd && (st == IDLE || (go && (bnd || enter)));
      nc    = apply ? shd : act;
      d_eff = nc.div < CNT_W'(2) ? CNT_W'(2) : nc.div;
      sum   = bnd ? {1'b0, acc} + {1'b0, nc.frac} : '0;
      p_n   = sum[FRAC_W] && ~&d_eff ? d_eff + 1'b1 : d_eff;
      h_n   = nc.high < p_n ? nc.high : p_n - 1'b1;
      h_eff = act.high < p ? act.high : p - 1'b1;
    end
    always_ff @(posedge clk) begin
      if (RST) begin
        st   <= IDLE;
        cnt  <= '0;
        dcnt <= '0;
        p    <= '0;
        acc  <= '0;
        act  <= DEF_CFG;
        shd  <= DEF_CFG;
        pnd  <= 1'b0;
        sn   <= 1'b0;
        o    <= 1'b0;
        pv   <= 1'b0;
        pl   <= '0;
      end else begin
        pv <= go && bnd;
        if (apply) begin
          act <= nc;
          pnd <= 1'b0;
        end
        if (take) begin
          shd <= '{div: cfg_div_int, high: cfg_high, phase: cfg_phase, frac: cfg_div_frac};
          pnd <= 1'b1;
        end
        if (!go) begin
          st  <= IDLE;
          o   <= 1'b0;
          cnt <= '0;
          acc <= '0;
          sn  <= 1'b0;
        end else if (st == IDLE && nc.phase != '0) begin
          st   <= DELAY;
          dcnt <= nc.phase - 1'b1;
        end else if (st == IDLE || enter || bnd) begin
          st  <= RUN;
          cnt <= '0;
          p   <= p_n;
          acc <= sum[FRAC_W-1:0];
          o   <= h_n != '0;
          if (bnd) begin
            pl <= p;
            sn <= 1'b1;
          end
        end else if (st == RUN) begin
          cnt <= cnt + 1'b1;
          o   <= cnt + 1'b1 < h_eff;
        end else begin
          dcnt <= dcnt - 1'b1;
        end
      end
    end
    assign out[i] = o;
    assign period_valid[i] = pv;
    assign period_last[i*CNT_W +: CNT_W] = pl;
    assign pend[i] = pnd;
    assign seen[i] = sn;
  end
endmodule

// File: tb/tb_multi_freq_gen.sv
// tb_multi_freq_gen: table-driven and scoreboard checks of multi_freq_gen with 2 channels, FRAC_W=3.
module tb_multi_freq_gen;
  logic clk = 1'b0;
  logic RST, PWRDWN, period_stable, cfg_valid, cfg_ready, locked;
  logic [0:0] cfg_ch;
  logic [15:0] cfg_div_int, cfg_high, cfg_phase;
  logic [2:0] cfg_div_frac;
  logic [1:0] out, period_valid, prev;
  logic [31:0] period_last;
  int n_vec = 0, n_bad = 0, cyc = 0, hcnt = 0, exp_h = 0, chk_h = 0, lk, highs, e0, pl_hold;
  int sb[$];
  int rise0[$];
  int rise1[$];
  typedef struct {
    int div, frac, high, hw, p0, p1, p2, p3, lk;
  } vec_t;
  vec_t tbl[6];

  multi_freq_gen #(.N(2), .CNT_W(16), .FRAC_W(3), .DEF_DIV(2), .DEF_HIGH(1)) dut (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .period_stable(period_stable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .cfg_high(cfg_high),
    .cfg_phase(cfg_phase), .out(out), .period_last(period_last),
    .period_valid(period_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (out[0] === 1'b1 && prev[0] !== 1'b1) rise0.push_back(cyc);
    if (out[1] === 1'b1 && prev[1] !== 1'b1) rise1.push_back(cyc);
    prev = out;
    if (out[0] === 1'b1) hcnt++;
    else begin
      if (chk_h != 0 && hcnt != 0) cmp("high_width0", hcnt, exp_h);
      hcnt = 0;
    end
    if (period_valid[0] === 1'b1 && sb.size() != 0) cmp("period_last0", int'(period_last[15:0]), sb.pop_front());
  endtask

  task automatic cfg(input int ch, input int d, input int f, input int h, input int ph);
    int b;
    b = 0;
    cfg_ch = 1'(ch);
    cfg_div_int = 16'(d);
    cfg_div_frac = 3'(f);
    cfg_high = 16'(h);
    cfg_phase = 16'(ph);
    cfg_valid = 1'b1;
    #1;
    while (cfg_ready !== 1'b1 && b < 50) begin
      step();
      b++;
    end
    if (cfg_ready !== 1'b1) cmp("cfg_ready_timeout", 0, 1);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    // div, frac, high, expected high width, first four period_last values, lock cycle
    tbl[0] = '{5, 4, 2, 2, 5, 5, 6, 5, 5};
    tbl[1] = '{6, 0, 0, 0, 6, 6, 6, 6, 6};
    tbl[2] = '{6, 0, 10, 5, 6, 6, 6, 6, 6};
    tbl[3] = '{1, 0, 1, 1, 2, 2, 2, 2, 2};
    tbl[4] = '{3, 7, 1, 1, 3, 3, 4, 4, 3};
    tbl[5] = '{0, 0, 5, 1, 2, 2, 2, 2, 2};
    prev = 2'b00;
    RST = 1'b1; PWRDWN = 1'b0; period_stable = 1'b1; cfg_valid = 1'b0; cfg_ch = 1'b0;
    cfg_div_int = '0; cfg_div_frac = '0; cfg_high = '0; cfg_phase = '0;
    for (int r = 0; r < 2; r++) begin
      step();
      cmp("rst_out", int'(out), 0);
      cmp("rst_locked", int'(locked), 0);
      cmp("rst_period_last", int'(period_last), 0);
      cmp("rst_cfg_ready", int'(cfg_ready), 1);
    end
    RST = 1'b0;
    period_stable = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      cfg(0, tbl[v].div, tbl[v].frac, tbl[v].high, 0);
      step();
      sb.delete();
      sb.push_back(tbl[v].p0); sb.push_back(tbl[v].p1);
      sb.push_back(tbl[v].p2); sb.push_back(tbl[v].p3);
      exp_h = tbl[v].hw; chk_h = 1; hcnt = 0; lk = -1; highs = 0;
      period_stable = 1'b1;
      for (int k = 0; k < 26; k++) begin
        step();
        if (k == 0) cmp("out_at_start", int'(out[0]), tbl[v].high > 0 ? 1 : 0);
        if (out[0] === 1'b1) highs++;
        if (locked === 1'b1 && lk < 0) lk = k;
      end
      cmp("lock_cycle", lk, tbl[v].lk);
      cmp("sb_left", sb.size(), 0);
      if (tbl[v].hw == 0) cmp("high0_count", highs, 0);
      chk_h = 0;
      period_stable = 1'b0;
      step();
    end

    // phase offset: ch1 lags ch0 by 3 cycles every period
    cfg(0, 4, 0, 2, 0);
    cfg(1, 4, 0, 2, 3);
    step();
    rise0.delete(); rise1.delete();
    e0 = cyc + 1;
    period_stable = 1'b1;
    for (int k = 0; k < 30; k++) step();
    cmp("rise_count", (rise0.size() >= 4 && rise1.size() >= 4) ? 1 : 0, 1);
    if (rise0.size() >= 4 && rise1.size() >= 4) begin
      cmp("ch0_first_rise", rise0[0], e0);
      cmp("ch1_first_rise", rise1[0], e0 + 3);
      for (int i = 0; i < 4; i++) cmp("phase_lag", rise1[i] - rise0[i], 3);
    end
    period_stable = 1'b0;
    step();

    // mid-period reprogram of ch0 from div 4 to div 8
    cfg(0, 4, 0, 2, 0);
    cfg(1, 2, 0, 1, 0);
    step();
    sb.delete();
    sb.push_back(4); sb.push_back(8); sb.push_back(8);
    exp_h = 2; chk_h = 1; hcnt = 0;
    period_stable = 1'b1;
    step();
    step();
    cfg_ch = 1'b0; cfg_div_int = 16'd8; cfg_div_frac = '0; cfg_high = 16'd2; cfg_phase = '0;
    cfg_valid = 1'b1;
    #1;
    cmp("ready_before_accept", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    #1;
    cmp("ready_pending", int'(cfg_ready), 0);
    step();
    cmp("ready_pending2", int'(cfg_ready), 0);
    cmp("no_early_boundary", int'(period_valid[0]), 0);
    step();
    cmp("boundary_pulse", int'(period_valid[0]), 1);
    cmp("ready_after_boundary", int'(cfg_ready), 1);
    for (int k = 0; k < 20; k++) step();
    cmp("reprog_sb_left", sb.size(), 0);
    chk_h = 0;
    period_stable = 1'b0;
    step();

    // PWRDWN pulse: outputs drop, restart aligned with accumulator cleared
    cfg(0, 5, 4, 2, 0);
    cfg(1, 2, 0, 1, 0);
    step();
    sb.delete();
    sb.push_back(5);
    period_stable = 1'b1;
    for (int k = 0; k < 8; k++) step();
    cmp("locked_before_pd", int'(locked), 1);
    PWRDWN = 1'b1;
    step();
    cmp("pd_out", int'(out), 0);
    cmp("pd_locked", int'(locked), 0);
    cmp("pd_period_last_hold", int'(period_last[15:0]), 5);
    PWRDWN = 1'b0;
    sb.push_back(5); sb.push_back(5); sb.push_back(6);
    step();
    cmp("restart_out", int'(out), 3);
    pl_hold = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 4) pl_hold = int'(period_last[15:0]);
    end
    cmp("restart_pl_hold", pl_hold, 5);
    cmp("restart_sb_left", sb.size(), 0);
    cmp("restart_locked", int'(locked), 1);

    // reset in the middle of a handshake while running
    cfg_ch = 1'b0; cfg_div_int = 16'd9; cfg_valid = 1'b1; RST = 1'b1;
    step();
    cfg_valid = 1'b0;
    cmp("rst2_cfg_ready", int'(cfg_ready), 1);
    cmp("rst2_out", int'(out), 0);
    cmp("rst2_period_last", int'(period_last), 0);
    cmp("rst2_locked", int'(locked), 0);
    cmp("rst2_period_valid", int'(period_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
